idft8_synth: RTL

Eight-point inverse DFT that turns a spectrum frame back into time-domain samples. It is the return path for the 8-bin forward transform.
- Accepts one frame of eight complex bins (32-bit real/imag pairs, same layout as the forward block's outputs) on a start pulse.
- Computes x[n] = (1/8)·Σk X[k]·e^{+j2πkn/8} with a single shared MAC.
- Streams x[0..7] out over a valid/ready handshake.

---
 rtl/idft8_synth.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/idft8_synth.sv
// -----------------------------------------------------------------------------
// idft8_synth -- 8-point inverse DFT, single shared complex MAC.
//
// Captures one frame of eight complex bins on a start pulse, then produces
// x[n] = (1/8) * sum_k X[k] * e^{+j2*pi*k*n/8} for n = 0..7. Each sample is
// streamed out over a valid/ready handshake.
//
// Parameters
//   TW_FRAC    fractional bits of the twiddle ROM (Q1.TW_FRAC, 16-bit signed)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle frame request, honoured only while busy=0
//   Xr0..Xr7   signed real part of bin k (sampled on the start cycle)
//   Xi0..Xi7   signed imaginary part of bin k (sampled on the start cycle)
//   busy       high from the cycle after start until the last sample transfers
//   out_valid  sample available
//   out_ready  consumer accepts the sample
//   out_idx    sample index n
//   out_re     signed real part of x[n]
//   out_im     signed imaginary part of x[n]
//
// Build option
//   IDFT_SAT_EN  when defined, results outside the 32-bit signed range clamp;
//                otherwise the low 32 bits are output (two's-complement wrap).
// -----------------------------------------------------------------------------
module idft8_synth #(
  parameter int TW_FRAC = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Xr0,
  input  logic [31:0] Xr1,
  input  logic [31:0] Xr2,
  input  logic [31:0] Xr3,
  input  logic [31:0] Xr4,
  input  logic [31:0] Xr5,
  input  logic [31:0] Xr6,
  input  logic [31:0] Xr7,
  input  logic [31:0] Xi0,
  input  logic [31:0] Xi1,
  input  logic [31:0] Xi2,
  input  logic [31:0] Xi3,
  input  logic [31:0] Xi4,
  input  logic [31:0] Xi5,
  input  logic [31:0] Xi6,
  input  logic [31:0] Xi7,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_idx,
  output logic [31:0] out_re,
  output logic [31:0] out_im
);

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  // Output shift folds the twiddle scale and the 1/8 factor together.
  localparam int SH = TW_FRAC + 3;
  localparam logic signed [52:0] RND = 53'sd1 <<< (SH - 1);

  // Twiddle magnitudes; cos(pi/4) ~= 46341/65536.
  localparam logic signed [15:0] TW_ONE = 16'(1 << TW_FRAC);
  localparam logic signed [15:0] TW_R2  = 16'(((1 << TW_FRAC) * 46341) >> 16);

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [2:0]         n_q, n_d;
  logic signed [52:0] acc_re_q, acc_re_d;
  logic signed [52:0] acc_im_q, acc_im_d;
  logic [7:0][31:0]   xr_q, xr_d;
  logic [7:0][31:0]   xi_q, xi_d;
  logic               busy_q, busy_d;
  logic               vld_q, vld_d;
  logic [2:0]         idx_q, idx_d;
  logic [31:0]        re_q, re_d;
  logic [31:0]        im_q, im_d;

  // ---------------------------------------------------------------------------
  // Shared MAC datapath
  // ---------------------------------------------------------------------------
  // Outside MAC the datapath is pointed at bin 0; its twiddle is always 1, so
  // the handshake edge can fold the k=0 term in without costing a cycle.
  logic [2:0]         mac_k;
  logic [2:0]         tw_t;
  logic signed [15:0] tw_c, tw_s;
  logic signed [31:0] xr_sel, xi_sel;
  logic signed [47:0] p_rc, p_is, p_rs, p_ic;
  logic signed [48:0] term_re, term_im;

  assign mac_k  = (state_q == MAC) ? k_q : 3'd0;
  assign tw_t   = mac_k * n_q;              // 3-bit wrap == mod 8
  assign xr_sel = xr_q[mac_k];
  assign xi_sel = xi_q[mac_k];

  always_comb begin
    tw_c = '0;
    tw_s = '0;
    unique case (tw_t)
      3'd0: begin tw_c =  TW_ONE; tw_s =  16'sd0;  end
      3'd1: begin tw_c =  TW_R2;  tw_s =  TW_R2;   end
      3'd2: begin tw_c =  16'sd0; tw_s =  TW_ONE;  end
      3'd3: begin tw_c = -TW_R2;  tw_s =  TW_R2;   end
      3'd4: begin tw_c = -TW_ONE; tw_s =  16'sd0;  end
      3'd5: begin tw_c = -TW_R2;  tw_s = -TW_R2;   end
      3'd6: begin tw_c =  16'sd0; tw_s = -TW_ONE;  end
      3'd7: begin tw_c =  TW_R2;  tw_s = -TW_R2;   end
      default: ;
    endcase
  end

  assign p_rc    = 48'(xr_sel) * 48'(tw_c);
  assign p_is    = 48'(xi_sel) * 48'(tw_s);
  assign p_rs    = 48'(xr_sel) * 48'(tw_s);
  assign p_ic    = 48'(xi_sel) * 48'(tw_c);
  assign term_re = 49'(p_rc) - 49'(p_is);
  assign term_im = 49'(p_rs) + 49'(p_ic);

  // Round half up, apply 1/8 and twiddle scale, narrow to 32 bits.
  function automatic logic [31:0] narrow(input logic signed [52:0] acc);
`ifdef IDFT_SAT_EN
    logic signed [52:0] r;
    r = (acc + RND) >>> SH;
    if (r > 53'sd2147483647)
      narrow = 32'h7FFF_FFFF;
    else if (r < -53'sd2147483648)
      narrow = 32'h8000_0000;
    else
      narrow = 32'(r);
`else
    narrow = 32'((acc + RND) >>> SH);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    xr_d     = xr_q;
    xi_d     = xi_q;
    busy_d   = busy_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    re_d     = re_q;
    im_d     = im_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          xr_d     = {Xr7, Xr6, Xr5, Xr4, Xr3, Xr2, Xr1, Xr0};
          xi_d     = {Xi7, Xi6, Xi5, Xi4, Xi3, Xi2, Xi1, Xi0};
          n_d      = 3'd0;
          k_d      = 3'd0;
          acc_re_d = '0;
          acc_im_d = '0;
          busy_d   = 1'b1;
          state_d  = MAC;
        end
      end

      MAC: begin
        acc_re_d = acc_re_q + 53'(term_re);
        acc_im_d = acc_im_q + 53'(term_im);
        k_d      = k_q + 3'd1;
        if (k_q == 3'd7) state_d = EMIT;
      end

      EMIT: begin
        if (!vld_q) begin
          // Load the output registers once; they then hold under backpressure.
          vld_d = 1'b1;
          idx_d = n_q;
          re_d  = narrow(acc_re_q);
          im_d  = narrow(acc_im_q);
        end else if (out_ready) begin
          vld_d = 1'b0;
          if (n_q == 3'd7) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Restart accumulation with the bin-0 term already included.
            n_d      = n_q + 3'd1;
            acc_re_d = 53'(term_re);
            acc_im_d = 53'(term_im);
            k_d      = 3'd1;
            state_d  = MAC;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      xr_q     <= '0;
      xi_q     <= '0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      re_q     <= '0;
      im_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      xr_q     <= xr_d;
      xi_q     <= xi_d;
      busy_q   <= busy_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      re_q     <= re_d;
      im_q     <= im_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign out_re    = re_q;
  assign out_im    = im_q;

endmodule
